muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same ID/EX fields the ALU decode uses (opcode, func3, func7) plus both source operands. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in a radix-2 multi-cycle datapath and raises `busy` to stall the pipeline until the result is ready. Divide-by-zero and signed-overflow cases bypass the iteration and complete in one cycle.

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M radix-2 multiply/divide beside the ALU: 33-cycle iterative ops, 1-cycle divide-by-zero/overflow fast path.
// busy stalls the pipeline from accept until the cycle before done; flush abandons the op without a done pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic [2:0]        op;
    logic              neg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   mag_b;

    logic              is_m;
    logic              accept;
    logic              sgn1, sgn2, s1, s2, neg_in;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_n;
    logic [XLEN-1:0]   rem_n;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, final_res;

    assign is_m   = (opcode == 7'b0110011) && (func7 == 7'b0000001);
    assign accept = start && is_m && (state == S_IDLE) && !flush;
    assign busy   = accept || ((state == S_CALC) && !flush);
    assign done   = (state == S_DONE);

    // Divides are signed on both sides for DIV/REM; MULHSU treats only rs1 as signed.
    assign sgn1   = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
    assign sgn2   = func3[2] ? ~func3[0] : ~func3[1];
    assign s1     = sgn1 & rs1_val[XLEN-1];
    assign s2     = sgn2 & rs2_val[XLEN-1];
    assign mag1   = s1 ? -rs1_val : rs1_val;
    assign mag2   = s2 ? -rs2_val : rs2_val;
    assign neg_in = (func3[2] & func3[1]) ? s1 : (s1 ^ s2);

    assign div_zero = func3[2] && (rs2_val == '0);
    assign div_ovf  = func3[2] && !func3[0] && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
    assign fast_res = div_zero ? (func3[1] ? rs1_val : {XLEN{1'b1}})
                               : (func3[1] ? '0 : 32'h8000_0000);

    // acc holds {partial product, remaining multiplier} or {0, dividend shifting into quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        acc_n     = {mul_sum, acc[XLEN-1:1]};
        rem_n     = rem;
        if (op[2]) begin
            acc_n = {{XLEN{1'b0}}, acc[XLEN-2:0], ~div_diff[XLEN]};
            rem_n = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        end
        prod = neg ? -acc_n : acc_n;
        quo  = neg ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        rmd  = neg ? -rem_n : rem_n;
        case (op)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rmd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op     <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            rem    <= '0;
            mag_b  <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op    <= func3;
                        neg   <= neg_in;
                        acc   <= {{XLEN{1'b0}}, mag1};
                        rem   <= '0;
                        mag_b <= mag2;
                        cnt   <= '0;
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_n;
                        rem <= rem_n;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result <= final_res;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

    localparam logic [6:0] OP_R = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] rs1_val, rs2_val;
    logic        busy, done;
    logic [31:0] result;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_res = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb, q, r;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin p = longint'(sa) * longint'(sb);                       return p[31:0];  end
            3'd1: begin p = longint'(sa) * longint'(sb);                       return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b});               return p[63:32]; end
            3'd3: begin p = longint'({32'b0, a}) * longint'({32'b0, b});       return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb;
                return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; opcode = OP_R; func7 = 7'b0000001; func3 = f3; rs1_val = a; rs2_val = b;
    endtask

    // Runs one accepted op and checks busy/done/result every cycle until it completes.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name, input bit hold);
        int lat;
        int busy_cnt;
        lat = is_fast(f3, a, b) ? 1 : 33;
        @(posedge clk); #1;
        drive_m(f3, a, b);
        @(negedge clk);
        chk({name, "_accept_busy"}, 32'(busy), 32'd1);
        chk({name, "_accept_done"}, 32'(done), 32'd0);
        busy_cnt = 1;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 1 && !hold) start = 1'b0;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (k < lat) begin
                chk({name, "_calc_done"}, 32'(done), 32'd0);
                chk({name, "_calc_result_held"}, result, last_res);
            end else begin
                chk({name, "_done"}, 32'(done), 32'd1);
                chk({name, "_done_busy"}, 32'(busy), 32'd0);
                chk({name, "_result"}, result, exp);
            end
        end
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
        last_res = exp;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({name, "_after_done"}, 32'(done), 32'd0);
        chk({name, "_after_busy"}, 32'(busy), 32'd0);
        chk({name, "_after_result"}, result, last_res);
    endtask

    task automatic directed(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] lit, input string name);
        chk({name, "_model"}, model(f3, a, b), lit);
        issue(f3, a, b, lit, name, bit'($urandom_range(0, 1)));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        opcode = '0; func3 = '0; func7 = '0; rs1_val = '0; rs2_val = '0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        directed(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        directed(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
        directed(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         "mulh_ff");
        directed(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
        directed(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
        directed(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
        directed(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_5_0");
        directed(3'd7, 32'd5,         32'd0,         32'd5,         "remu_5_0");
        directed(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        directed(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf");

        // Non-M instructions must be ignored.
        @(posedge clk); #1;
        start = 1'b1; opcode = OP_R; func7 = 7'b0000000; func3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("add_busy", 32'(busy), 32'd0);
            chk("add_done", 32'(done), 32'd0);
            chk("add_result", result, last_res);
            if (k == 3) begin
                @(posedge clk); #1;
                opcode = 7'b0010011; func7 = 7'b0000001;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;

        // start and flush together never accept.
        @(posedge clk); #1;
        drive_m(3'd0, 32'd9, 32'd9);
        flush = 1'b1;
        @(negedge clk);
        chk("startflush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("startflush_no_done", 32'(done), 32'd0);
        end

        // Flush in the 10th CALC cycle of a DIVU.
        @(posedge clk); #1;
        drive_m(3'd5, 32'd1000, 32'd7);
        @(negedge clk);
        chk("flush_accept_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("flush_calc_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_drop", 32'(busy), 32'd0);
        chk("flush_cycle_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("flush_no_done", 32'(done), 32'd0);
            chk("flush_idle_busy", 32'(busy), 32'd0);
            chk("flush_result_kept", result, last_res);
        end
        directed(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_flush");

        // Reset pulse mid-CALC.
        @(posedge clk); #1;
        drive_m(3'd0, 32'd123, 32'd456);
        for (int k = 0; k < 15; k++) @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        last_res = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        directed(3'd0, 32'd123, 32'd456, 32'd56088, "mul_after_reset");

        for (int n = 0; n < 80; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(f3, a, b, model(f3, a, b), $sformatf("rand%0d_f%0d", n, f3), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
